// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder: FSM state encoding and counter widths.
package systolic_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int BUBBLE_CNT_W = 16;

endpackage

// File: rtl/systolic_feeder_skew.sv
// skew_delay_line: resettable {valid, data} shift register of DEPTH stages, one per lane.
module skew_delay_line #(
   parameter int DEPTH    = 1,
   parameter int BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [BITWIDTH-1:0] in_data,
   output logic                out_valid,
   output logic [BITWIDTH-1:0] out_data
);

   logic [DEPTH-1:0][BITWIDTH:0] stage;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage[0] <= {in_valid, in_data};
         for (int j = 1; j < DEPTH; j++) stage[j] <= stage[j-1];
      end
   end

   assign out_valid = stage[DEPTH-1][BITWIDTH];
   assign out_data  = stage[DEPTH-1][BITWIDTH-1:0];

endmodule

// File: rtl/systolic_feeder.sv
// Diagonal-skew input stager for the systolic array; streams k_len beats per start, then drains.
// Optional FEEDER_BUBBLE_CNT_EN adds bubble_cnt (STREAM cycles without input, saturating).
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int ARRAY_SIZE = 4,
   parameter int BITWIDTH   = 8,
   parameter int K_WIDTH    = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [K_WIDTH-1:0]             k_len,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ARRAY_SIZE*BITWIDTH-1:0] in_data,
   output logic [ARRAY_SIZE*BITWIDTH-1:0] out_data,
   output logic [ARRAY_SIZE-1:0]          out_valid,
   output logic                           busy,
   output logic                           done
`ifdef FEEDER_BUBBLE_CNT_EN
   ,
   output logic [BUBBLE_CNT_W-1:0]        bubble_cnt
`endif
);

   localparam int DW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

   state_t             state;
   logic [K_WIDTH-1:0] beat_cnt;
   logic [DW-1:0]      drain_cnt;
   logic               accept;

   assign accept = in_valid && in_ready;

   // drain_cnt counts down the ARRAY_SIZE drain cycles; done is raised on entry to the last one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (k_len != '0) begin
                     state    <= STREAM;
                     beat_cnt <= k_len;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (accept) begin
                  beat_cnt <= beat_cnt - 1'b1;
                  if (beat_cnt == K_WIDTH'(1)) begin
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     drain_cnt <= DW'(ARRAY_SIZE - 1);
                     done      <= (ARRAY_SIZE == 1);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
                  done      <= (drain_cnt == DW'(1));
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

`ifdef FEEDER_BUBBLE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bubble_cnt <= '0;
      else if (state == IDLE && start)
         bubble_cnt <= '0;
      else if (state == STREAM && !in_valid && bubble_cnt != '1)
         bubble_cnt <= bubble_cnt + 1'b1;
   end
`endif

   // Non-accepted cycles enter as zero-data bubbles so the MACs see harmless operands
   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      logic [BITWIDTH-1:0] lane_in;
      assign lane_in = accept ? in_data[i*BITWIDTH +: BITWIDTH] : '0;

      skew_delay_line #(
         .DEPTH    (i + 1),
         .BITWIDTH (BITWIDTH)
      ) u_skew (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (accept),
         .in_data   (lane_in),
         .out_valid (out_valid[i]),
         .out_data  (out_data[i*BITWIDTH +: BITWIDTH])
      );
   end

endmodule
